// File: rtl/fpu_bcd_to_binary.sv
// Purpose: iterative 18-digit packed-BCD to 64-bit binary converter (FBLD load path).
// Latency: 18 cycles from capture for a valid operand, result on the capture edge for an invalid one.
// Backpressure: level-held enable/done; done holds until enable drops, enable low mid-convert aborts.
module fpu_bcd_to_binary (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [79:0] bcd_in,
    output logic [63:0] binary_out,
    output logic        sign_out,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t      state, state_nxt;
    logic [71:0] digits, digits_nxt;
    logic [63:0] acc, acc_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [63:0] bin_nxt;
    logic        sign_nxt;
    logic        err_nxt;
    logic        done_nxt;
    logic        bad_digit;
    logic [63:0] acc_step;

    // Bits 78:72 of the operand carry no meaning and are deliberately dropped.
    logic        unused_pad_bits;
    assign unused_pad_bits = ^bcd_in[78:72];

    // Flag any nibble of the incoming operand that is not a decimal digit.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (bcd_in[i*4 +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One Horner step: acc*10 + current MSD; the operand shifts left so the next digit is always at the top.
    assign acc_step = (acc << 3) + (acc << 1) + {60'd0, digits[71:68]};

    // Next-state and next-output logic for the capture / convert / hold sequence.
    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        acc_nxt    = acc;
        idx_nxt    = idx;
        bin_nxt    = binary_out;
        sign_nxt   = sign_out;
        err_nxt    = error;
        case (state)
            IDLE: begin
                if (enable) begin
                    digits_nxt = bcd_in[71:0];
                    sign_nxt   = bcd_in[79];
                    if (bad_digit) begin
                        err_nxt   = 1'b1;
                        bin_nxt   = 64'd0;
                        state_nxt = DONE;
                    end else begin
                        err_nxt   = 1'b0;
                        acc_nxt   = 64'd0;
                        idx_nxt   = 5'd17;
                        state_nxt = CONVERT;
                    end
                end
            end
            CONVERT: begin
                if (!enable) begin
                    // Abandon the request; the partial accumulator is never published.
                    state_nxt = IDLE;
                end else begin
                    acc_nxt    = acc_step;
                    digits_nxt = digits << 4;
                    if (idx == 5'd0) begin
                        bin_nxt   = acc_step;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx - 5'd1;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == DONE);
    end

    // Register all state and outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            digits     <= 72'd0;
            acc        <= 64'd0;
            idx        <= 5'd0;
            binary_out <= 64'd0;
            sign_out   <= 1'b0;
            error      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            digits     <= digits_nxt;
            acc        <= acc_nxt;
            idx        <= idx_nxt;
            binary_out <= bin_nxt;
            sign_out   <= sign_nxt;
            error      <= err_nxt;
            done       <= done_nxt;
        end
    end

endmodule
